// File: rtl/led_scan_controller.sv
// Multiplexed 4-digit 7-segment scanner with dead-time blanking and a frame-synced display buffer; LEDSCAN_BLINK_EN adds frame-rate blink.
// All outputs registered alongside the state register; no backpressure, load is accepted on any cycle.
module led_scan_controller #(
  parameter int DIGIT_CYCLES = 25000,
  parameter int DEAD_CYCLES  = 16,
  parameter int CNT_W        = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic        blink,
  output logic [3:0]  char,
  output logic [3:0]  anode,
  output logic        pending,
  output logic        frame_done
);

  typedef enum logic {BLANK, DRIVE} state_t;

  localparam logic [3:0]       SPACE      = 4'hC;
  localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);

  state_t           state, state_n;
  logic [1:0]       digit, digit_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [15:0]      shadow, shadow_n;
  logic [15:0]      active, active_n;
  logic             pending_n;
  logic             frame_done_n;
  logic [3:0]       anode_n, char_n;
  logic             blink_on_n;
  logic             lit;

  always_comb begin
    state_n      = state;
    digit_n      = digit;
    cnt_n        = cnt;
    shadow_n     = shadow;
    active_n     = active;
    pending_n    = pending;
    frame_done_n = 1'b0;
    if (!enable) begin
      state_n = BLANK;
      digit_n = 2'd0;
      cnt_n   = '0;
    end else if (state == BLANK) begin
      if (cnt == DEAD_LAST) begin
        cnt_n   = '0;
        state_n = DRIVE;
        // Commit only ahead of digit 0 so a frame never mixes two words
        if (digit == 2'd0 && pending) begin
          active_n  = shadow;
          pending_n = 1'b0;
        end
      end else begin
        cnt_n = cnt + CNT_W'(1);
      end
    end else begin
      if (cnt == DIGIT_LAST) begin
        cnt_n        = '0;
        digit_n      = digit + 2'd1;
        state_n      = BLANK;
        frame_done_n = (digit == 2'd3);
      end else begin
        cnt_n = cnt + CNT_W'(1);
      end
    end
    // A load on the commit cycle lands after the commit read the old shadow
    if (load) begin
      shadow_n  = data_in;
      pending_n = 1'b1;
    end
  end

  // Outputs decode the next state so they align with the registered state
  always_comb begin
    lit     = (state_n == DRIVE) && blink_on_n;
    anode_n = 4'b1111;
    char_n  = SPACE;
    if (lit) begin
      anode_n = ~(4'b0001 << digit_n);
      char_n  = active_n[{digit_n, 2'b00} +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= BLANK;
      digit      <= 2'd0;
      cnt        <= '0;
      shadow     <= 16'hCCCC;
      active     <= 16'hCCCC;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      anode      <= 4'b1111;
      char       <= SPACE;
    end else begin
      state      <= state_n;
      digit      <= digit_n;
      cnt        <= cnt_n;
      shadow     <= shadow_n;
      active     <= active_n;
      pending    <= pending_n;
      frame_done <= frame_done_n;
      anode      <= anode_n;
      char       <= char_n;
    end
  end

`ifdef LEDSCAN_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FC_W-1:0] frame_cnt, frame_cnt_n;
  logic            blink_phase, blink_phase_n;

  always_comb begin
    frame_cnt_n   = frame_cnt;
    blink_phase_n = blink_phase;
    if (!blink) begin
      frame_cnt_n   = '0;
      blink_phase_n = 1'b1;
    end else if (frame_done) begin
      if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_n   = '0;
        blink_phase_n = ~blink_phase;
      end else begin
        frame_cnt_n = frame_cnt + FC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      frame_cnt   <= frame_cnt_n;
      blink_phase <= blink_phase_n;
    end
  end

  assign blink_on_n = blink_phase_n;
`else
  logic unused_blink;
  assign unused_blink = blink;
  assign blink_on_n   = 1'b1;
`endif

endmodule

// File: tb/tb_led_scan_controller.sv
// Directed bench for led_scan_controller with DIGIT_CYCLES=4, DEAD_CYCLES=2 (24-cycle frame).
// ph tracks cycles since the scan last sat in BLANK/digit0/cnt0; expected outputs derive from it.
module tb_led_scan_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        load;
  logic [15:0] data_in;
  logic        blink;
  logic [3:0]  char;
  logic [3:0]  anode;
  logic        pending;
  logic        frame_done;

  int tests = 0;
  int fails = 0;
  int ph    = 0;

`ifdef LEDSCAN_BLINK_EN
  localparam bit BLINK_FEAT = 1'b1;
`else
  localparam bit BLINK_FEAT = 1'b0;
`endif

  led_scan_controller #(
    .DIGIT_CYCLES(4),
    .DEAD_CYCLES (2),
    .CNT_W       (4),
    .BLINK_FRAMES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .load      (load),
    .data_in   (data_in),
    .blink     (blink),
    .char      (char),
    .anode     (anode),
    .pending   (pending),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_anode(input int p, input bit dark);
    int q;
    q = p % 24;
    if ((q % 6) < 2 || dark) return 4'b1111;
    return ~(4'b0001 << (q / 6));
  endfunction

  function automatic logic [3:0] exp_char(input int p, input logic [15:0] w, input bit dark);
    int q;
    q = p % 24;
    if ((q % 6) < 2 || dark) return 4'hC;
    return w[(q / 6) * 4 +: 4];
  endfunction

  function automatic logic exp_fd(input int p);
    return (p > 0) && (p % 24 == 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (!reset || !enable) ph = 0;
    else ph++;
  endtask

  task automatic advance_to(input int target);
    int n;
    n = (target - (ph % 24) + 24) % 24;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; load = 1'b0; data_in = 16'h0; blink = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (anode !== 4'b1111) begin fails++; $display("FAIL reset_anode got=%b exp=1111", anode); end
      tests++; if (char !== 4'hC) begin fails++; $display("FAIL reset_char got=%h exp=c", char); end
      tests++; if (pending !== 1'b0) begin fails++; $display("FAIL reset_pending got=%b exp=0", pending); end
      tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
    end
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      tests++; if (anode !== exp_anode(ph, 0)) begin fails++; $display("FAIL run_anode ph=%0d got=%b exp=%b", ph, anode, exp_anode(ph, 0)); end
      tests++; if (char !== exp_char(ph, 16'hCCCC, 0)) begin fails++; $display("FAIL run_char ph=%0d got=%h exp=%h", ph, char, exp_char(ph, 16'hCCCC, 0)); end
      tests++; if (frame_done !== exp_fd(ph)) begin fails++; $display("FAIL run_fd ph=%0d got=%b exp=%b", ph, frame_done, exp_fd(ph)); end
    end
  endtask

  task automatic test_load();
    advance_to(8);
    load = 1'b1; data_in = 16'h3210;
    tick();
    load = 1'b0;
    tests++; if (pending !== 1'b1) begin fails++; $display("FAIL load_pending got=%b exp=1", pending); end
    for (int i = 0; i < 24; i++) begin
      if (ph % 24 == 1) break;
      tick();
      tests++; if (pending !== 1'b1) begin fails++; $display("FAIL load_hold ph=%0d got=%b exp=1", ph, pending); end
      tests++; if (char !== exp_char(ph, 16'hCCCC, 0)) begin fails++; $display("FAIL load_old ph=%0d got=%h exp=%h", ph, char, exp_char(ph, 16'hCCCC, 0)); end
    end
    for (int i = 0; i < 24; i++) begin
      tick();
      tests++; if (pending !== 1'b0) begin fails++; $display("FAIL load_commit ph=%0d got=%b exp=0", ph, pending); end
      tests++; if (anode !== exp_anode(ph, 0)) begin fails++; $display("FAIL load_anode ph=%0d got=%b exp=%b", ph, anode, exp_anode(ph, 0)); end
      tests++; if (char !== exp_char(ph, 16'h3210, 0)) begin fails++; $display("FAIL load_char ph=%0d got=%h exp=%h", ph, char, exp_char(ph, 16'h3210, 0)); end
      tests++; if (frame_done !== exp_fd(ph)) begin fails++; $display("FAIL load_fd ph=%0d got=%b exp=%b", ph, frame_done, exp_fd(ph)); end
    end
  endtask

  task automatic test_back_to_back();
    advance_to(4);
    load = 1'b1; data_in = 16'h1111;
    tick();
    load = 1'b0;
    tick(); tick();
    load = 1'b1; data_in = 16'h9876;
    tick();
    load = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (ph % 24 == 1) break;
      tick();
      tests++; if (char !== exp_char(ph, 16'h3210, 0)) begin fails++; $display("FAIL b2b_old ph=%0d got=%h exp=%h", ph, char, exp_char(ph, 16'h3210, 0)); end
    end
    for (int i = 0; i < 24; i++) begin
      tick();
      tests++; if (anode !== exp_anode(ph, 0)) begin fails++; $display("FAIL b2b_anode ph=%0d got=%b exp=%b", ph, anode, exp_anode(ph, 0)); end
      tests++; if (char !== exp_char(ph, 16'h9876, 0)) begin fails++; $display("FAIL b2b_char ph=%0d got=%h exp=%h", ph, char, exp_char(ph, 16'h9876, 0)); end
    end
  endtask

  task automatic test_commit_cycle();
    advance_to(10);
    load = 1'b1; data_in = 16'hA5A5;
    tick();
    load = 1'b0;
    advance_to(1);
    load = 1'b1; data_in = 16'h4321;
    tick();
    load = 1'b0;
    tests++; if (pending !== 1'b1) begin fails++; $display("FAIL cc_pending got=%b exp=1", pending); end
    tests++; if (char !== 4'h5) begin fails++; $display("FAIL cc_first_char got=%h exp=5", char); end
    for (int i = 0; i < 23; i++) begin
      tick();
      tests++; if (pending !== 1'b1) begin fails++; $display("FAIL cc_hold ph=%0d got=%b exp=1", ph, pending); end
      tests++; if (char !== exp_char(ph, 16'hA5A5, 0)) begin fails++; $display("FAIL cc_old ph=%0d got=%h exp=%h", ph, char, exp_char(ph, 16'hA5A5, 0)); end
    end
    for (int i = 0; i < 24; i++) begin
      tick();
      tests++; if (pending !== 1'b0) begin fails++; $display("FAIL cc_commit ph=%0d got=%b exp=0", ph, pending); end
      tests++; if (char !== exp_char(ph, 16'h4321, 0)) begin fails++; $display("FAIL cc_new ph=%0d got=%h exp=%h", ph, char, exp_char(ph, 16'h4321, 0)); end
    end
  endtask

  task automatic test_enable();
    advance_to(15);
    tests++; if (anode !== 4'b1011 || char !== 4'h3) begin fails++; $display("FAIL en_pre got=%b/%h exp=1011/3", anode, char); end
    enable = 1'b0;
    tick();
    tests++; if (anode !== 4'b1111 || char !== 4'hC) begin fails++; $display("FAIL en_off got=%b/%h exp=1111/c", anode, char); end
    load = 1'b1; data_in = 16'h0FED;
    tick();
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (anode !== 4'b1111 || char !== 4'hC || frame_done !== 1'b0) begin
        fails++; $display("FAIL en_held got=%b/%h/%b exp=1111/c/0", anode, char, frame_done);
      end
      tests++; if (pending !== 1'b1) begin fails++; $display("FAIL en_pending got=%b exp=1", pending); end
    end
    enable = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      tests++; if (anode !== exp_anode(ph, 0)) begin fails++; $display("FAIL en_anode ph=%0d got=%b exp=%b", ph, anode, exp_anode(ph, 0)); end
      tests++; if (char !== exp_char(ph, 16'h0FED, 0)) begin fails++; $display("FAIL en_char ph=%0d got=%h exp=%h", ph, char, exp_char(ph, 16'h0FED, 0)); end
      tests++; if (frame_done !== exp_fd(ph)) begin fails++; $display("FAIL en_fd ph=%0d got=%b exp=%b", ph, frame_done, exp_fd(ph)); end
      tests++; if (pending !== (ph < 2)) begin fails++; $display("FAIL en_commit ph=%0d got=%b exp=%b", ph, pending, ph < 2); end
    end
  endtask

  task automatic test_blink();
    int  f0;
    bit  dark;
    advance_to(2);
    f0    = ph / 24;
    blink = 1'b1;
    for (int i = 0; i < 190; i++) begin
      if (i == 160) blink = 1'b0;
      tick();
      dark = BLINK_FEAT && blink && ((((ph / 24) - f0) / 2) % 2 == 1);
      tests++; if (anode !== exp_anode(ph, dark)) begin fails++; $display("FAIL blink_anode ph=%0d got=%b exp=%b", ph, anode, exp_anode(ph, dark)); end
      tests++; if (char !== exp_char(ph, 16'h0FED, dark)) begin fails++; $display("FAIL blink_char ph=%0d got=%h exp=%h", ph, char, exp_char(ph, 16'h0FED, dark)); end
      tests++; if (frame_done !== exp_fd(ph)) begin fails++; $display("FAIL blink_fd ph=%0d got=%b exp=%b", ph, frame_done, exp_fd(ph)); end
    end
  endtask

  task automatic test_reset_midframe();
    advance_to(15);
    reset = 1'b0; load = 1'b1; data_in = 16'h7777;
    tick();
    load = 1'b0;
    tests++; if (anode !== 4'b1111 || char !== 4'hC) begin fails++; $display("FAIL rmid_out got=%b/%h exp=1111/c", anode, char); end
    tests++; if (pending !== 1'b0) begin fails++; $display("FAIL rmid_pending got=%b exp=0", pending); end
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      tests++; if (char !== exp_char(ph, 16'hCCCC, 0) || anode !== exp_anode(ph, 0)) begin
        fails++; $display("FAIL rmid_run ph=%0d got=%b/%h exp=%b/%h", ph, anode, char, exp_anode(ph, 0), exp_char(ph, 16'hCCCC, 0));
      end
    end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; load = 1'b0; data_in = 16'h0; blink = 1'b0;
    test_reset();
    test_load();
    test_back_to_back();
    test_commit_cycle();
    test_enable();
    test_blink();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
